rom_loader: RTL and testbench

Download-side feeder for the SDRAM controller's ROM write port. Packs the byte-wide cartridge download stream into 16-bit words and buffers them in a small FIFO. Issues each word to the controller over the toggle request/acknowledge handshake (`romwr_req`/`romwr_ack`) and reports ROM size and completion to the core. Sits between the I/O download interface and the SDRAM controller.

---
 rtl/rom_loader.sv | 162 ++++++++++++++++
 tb/tb_rom_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - packs download bytes into 16-bit words and issues them to the SDRAM ROM write port
// Define ROM_LOADER_BSWAP_EN for big-endian packing (even byte in [15:8]); default is little-endian.
module rom_loader #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        romwr_req,
   input  logic        romwr_ack,
   output logic [22:0] romwr_a,
   output logic [15:0] romwr_d,
   output logic [24:0] rom_size,
   output logic        busy,
   output logic        done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]   WAIT_CNT = FULL_CNT - CNT_ONE;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   function automatic logic [15:0] pack(input logic [7:0] even_b, input logic [7:0] odd_b);
`ifdef ROM_LOADER_BSWAP_EN
      return {even_b, odd_b};
`else
      return {odd_b, even_b};
`endif
   endfunction

   logic          dl_q;
   logic          dl_rise, dl_fall, acc, lat_live, req_idle;
   logic          lat_valid;
   logic [7:0]    lat_byte;
   logic [22:0]   lat_addr;
   logic [24:0]   addr_inc;
   logic          push, push_ok, pop, issue;
   logic [38:0]   push_entry;
   logic [38:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   state_t        state, state_next;

   assign dl_rise  = ioctl_download & ~dl_q;
   assign dl_fall  = ~ioctl_download & dl_q;
   assign acc      = ioctl_wr & ~ioctl_addr[24];
   assign lat_live = lat_valid & ~dl_rise;
   assign addr_inc = ioctl_addr + 25'd1;
   assign req_idle = (romwr_req == romwr_ack);
   assign push_ok  = push & (count != FULL_CNT);
   assign pop      = issue;
   assign busy     = ioctl_download | (count != '0) | (state != S_IDLE) | ~req_idle;

   // An odd strobe always wins; a flush can only occur once strobes have stopped.
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (acc && ioctl_addr[0]) begin
         push       = 1'b1;
         push_entry = {ioctl_addr[23:1], pack(lat_live ? lat_byte : PAD_BYTE, ioctl_dout)};
      end else if (dl_fall && lat_valid) begin
         push       = 1'b1;
         push_entry = {lat_addr, pack(lat_byte, PAD_BYTE)};
      end
   end

   always_comb begin
      count_next = count;
      if (push_ok && !pop)
         count_next = count + CNT_ONE;
      else if (!push_ok && pop)
         count_next = count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dl_q       <= 1'b0;
         lat_valid  <= 1'b0;
         lat_byte   <= '0;
         lat_addr   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ioctl_wait <= 1'b0;
         rom_size   <= '0;
         done       <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         count      <= count_next;
         ioctl_wait <= (count_next >= WAIT_CNT);
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;

         if (acc && !ioctl_addr[0]) begin
            lat_valid <= 1'b1;
            lat_byte  <= ioctl_dout;
            lat_addr  <= ioctl_addr[23:1];
         end else if (push || dl_rise) begin
            lat_valid <= 1'b0;
         end

         if (dl_rise)
            rom_size <= acc ? addr_inc : '0;
         else if (acc && (addr_inc > rom_size))
            rom_size <= addr_inc;

         // A flush push in this cycle means the FIFO is not really drained yet.
         if (dl_rise)
            done <= 1'b0;
         else if (!ioctl_download && !push && (count == '0) && (state == S_IDLE) && req_idle)
            done <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         romwr_req <= romwr_ack;
         romwr_a   <= '0;
         romwr_d   <= '0;
      end else if (issue) begin
         romwr_req          <= ~romwr_req;
         {romwr_a, romwr_d} <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if ((count != '0) && req_idle) state_next = S_WAIT;
         S_WAIT:  if (req_idle) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // The issue step happens in the IDLE cycle that sees a word, so the toggle lands one edge later.
   always_comb begin
      issue = 1'b0;
      if ((state == S_IDLE) && (count != '0) && req_idle)
         issue = 1'b1;
   end
endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed bench for rom_loader with a toggle-handshake controller model
module tb_rom_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wait;
   logic        romwr_req;
   logic        romwr_ack;
   logic [22:0] romwr_a;
   logic [15:0] romwr_d;
   logic [24:0] rom_size;
   logic        busy;
   logic        done;

   logic        ack_ctl = 1'b0;
   logic        ack_flip = 1'b0;
   logic        ctl_en = 1'b1;
   int          ack_delay = 5;
   logic [22:0] wa [$];
   logic [15:0] wd [$];
   int          n_vec = 0;
   int          n_err = 0;

`ifdef ROM_LOADER_BSWAP_EN
   localparam logic [15:0] W_T1 = 16'h1234, W_T2A = 16'hAABB, W_T2B = 16'hCCFF, W_T6 = 16'h99FF;
`else
   localparam logic [15:0] W_T1 = 16'h3412, W_T2A = 16'hBBAA, W_T2B = 16'hFFCC, W_T6 = 16'hFF99;
`endif

   assign romwr_ack = ack_ctl ^ ack_flip;

   always #5 clk = ~clk;

   rom_loader #(.FIFO_DEPTH(4), .PAD_BYTE(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .romwr_req(romwr_req), .romwr_ack(romwr_ack),
      .romwr_a(romwr_a), .romwr_d(romwr_d),
      .rom_size(rom_size), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Controller model: capture each new request, hold it for ack_delay cycles, then acknowledge.
   initial begin
      logic [22:0] a;
      logic [15:0] d;
      forever begin
         @(posedge clk);
         #1;
         if (ctl_en && !reset && (romwr_req != romwr_ack)) begin
            a = romwr_a;
            d = romwr_d;
            wa.push_back(a);
            wd.push_back(d);
            repeat (ack_delay) @(posedge clk);
            #1;
            check("hold_a", {9'd0, romwr_a}, {9'd0, a});
            check("hold_d", {16'd0, romwr_d}, {16'd0, d});
            ack_ctl = romwr_req ^ ack_flip;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 1000 && !done; i++)
         tick();
      check(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int base;
      logic wait_seen;
      logic [7:0] eb, ob;

      // Reset state
      repeat (2) tick();
      check("rst_req", {31'd0, romwr_req}, 32'd0);
      check("rst_a", {9'd0, romwr_a}, 32'd0);
      check("rst_d", {16'd0, romwr_d}, 32'd0);
      check("rst_size", {7'd0, rom_size}, 32'd0);
      check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Single word, ack after 5 cycles, request toggle latency
      base = wa.size();
      ack_delay = 5;
      ioctl_download = 1'b1;
      tick();
      wr_byte(25'h0, 8'h12);
      wr_byte(25'h1, 8'h34);
      check("t1_req_not_yet", {31'd0, romwr_req ^ romwr_ack}, 32'd0);
      tick();
      check("t1_req_toggled", {31'd0, romwr_req ^ romwr_ack}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_done_low", {31'd0, done}, 32'd0);
      ioctl_download = 1'b0;
      wait_done("t1_done");
      check("t1_nwr", wa.size() - base, 32'd1);
      if (wa.size() > base) begin
         check("t1_a", {9'd0, wa[base]}, 32'd0);
         check("t1_d", {16'd0, wd[base]}, {16'd0, W_T1});
      end
      check("t1_size", {7'd0, rom_size}, 32'd2);

      // Three bytes with trailing flush, plus a dropped high-address byte
      base = wa.size();
      ioctl_download = 1'b1;
      tick();
      wr_byte(25'h0, 8'hAA);
      wr_byte(25'h1, 8'hBB);
      wr_byte(25'h2, 8'hCC);
      wr_byte(25'h1000001, 8'h55);
      check("t2_size_hi_drop", {7'd0, rom_size}, 32'd3);
      ioctl_download = 1'b0;
      wait_done("t2_done");
      check("t2_nwr", wa.size() - base, 32'd2);
      if (wa.size() >= base + 2) begin
         check("t2_a0", {9'd0, wa[base]}, 32'd0);
         check("t2_d0", {16'd0, wd[base]}, {16'd0, W_T2A});
         check("t2_a1", {9'd0, wa[base+1]}, 32'd1);
         check("t2_d1", {16'd0, wd[base+1]}, {16'd0, W_T2B});
      end
      check("t2_size", {7'd0, rom_size}, 32'd3);

      // Backpressure: 16 bytes against a slow controller
      base = wa.size();
      ack_delay = 20;
      wait_seen = 1'b0;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         for (int t = 0; t < 200 && ioctl_wait; t++) begin
            wait_seen = 1'b1;
            tick();
         end
         wr_byte(25'(i), 8'h40 + 8'(i));
      end
      ioctl_download = 1'b0;
      wait_done("t5_done");
      check("t5_wait_seen", {31'd0, wait_seen}, 32'd1);
      check("t5_wait_end", {31'd0, ioctl_wait}, 32'd0);
      check("t5_nwr", wa.size() - base, 32'd8);
      for (int k = 0; k < 8 && (base + k) < wa.size(); k++) begin
         eb = 8'h40 + 8'(2 * k);
         ob = 8'h41 + 8'(2 * k);
         check("t5_a", {9'd0, wa[base+k]}, k);
`ifdef ROM_LOADER_BSWAP_EN
         check("t5_d", {16'd0, wd[base+k]}, {16'd0, eb, ob});
`else
         check("t5_d", {16'd0, wd[base+k]}, {16'd0, ob, eb});
`endif
      end
      check("t5_size", {7'd0, rom_size}, 32'd16);

      // Second download after done: done and rom_size restart
      base = wa.size();
      ack_delay = 3;
      ioctl_download = 1'b1;
      tick();
      check("t6_done_clr", {31'd0, done}, 32'd0);
      check("t6_size_clr", {7'd0, rom_size}, 32'd0);
      wr_byte(25'h0, 8'h99);
      check("t6_size1", {7'd0, rom_size}, 32'd1);
      ioctl_download = 1'b0;
      wait_done("t6_done");
      check("t6_nwr", wa.size() - base, 32'd1);
      if (wa.size() > base) begin
         check("t6_a", {9'd0, wa[base]}, 32'd0);
         check("t6_d", {16'd0, wd[base]}, {16'd0, W_T6});
      end

      // Reset with romwr_ack high: request follows ack, nothing issued
      base = wa.size();
      ctl_en = 1'b0;
      if (romwr_ack == 1'b0)
         ack_flip = ~ack_flip;
      reset = 1'b1;
      repeat (2) tick();
      check("t7_req_rst", {31'd0, romwr_req}, 32'd1);
      reset = 1'b0;
      repeat (10) tick();
      check("t7_req_hold", {31'd0, romwr_req}, 32'd1);
      check("t7_busy", {31'd0, busy}, 32'd0);
      check("t7_done", {31'd0, done}, 32'd1);
      check("t7_nwr", wa.size() - base, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
